// File: rtl/oled_pkg.sv
// oled_pkg: shared state encoding and constants for the OLED SPI transmitter
package oled_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_e;
  localparam logic DC_CMD = 1'b0;
  localparam logic DC_DATA = 1'b1;
  localparam int SPI_BITS = 8;
endpackage

// File: rtl/oled_byte_fifo.sv
// oled_byte_fifo: {dc,data} FIFO with registered full/empty; writes while full are dropped and flagged
module oled_byte_fifo #(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en_i,
  input  logic [8:0]    wr_data_i,
  input  logic          pop_i,
  output logic [8:0]    head_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   level_o,
  output logic          ovf_o
);
  logic [8:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] level_q, level_d;
  logic full_q, empty_q, ovf_q, push, pop;
  always_comb begin
    push = wr_en_i & ~full_q;
    pop = pop_i & ~empty_q;
    level_d = level_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_ff @(posedge clk) if (push) mem_q[wr_q] <= wr_data_i;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      level_q <= '0;
      full_q <= 1'b0;
      empty_q <= 1'b1;
      ovf_q <= 1'b0;
    end else begin
      wr_q <= push ? wr_q + AW'(1) : wr_q;
      rd_q <= pop ? rd_q + AW'(1) : rd_q;
      level_q <= level_d;
      full_q <= level_d == (AW+1)'(DEPTH);
      empty_q <= level_d == '0;
      ovf_q <= ovf_q | (wr_en_i & full_q);
    end
  end
  assign head_o = mem_q[rd_q];
  assign full_o = full_q;
  assign empty_o = empty_q;
  assign level_o = level_q;
  assign ovf_o = ovf_q;
endmodule

// File: rtl/oled_spi_tx.sv
// oled_spi_tx: queued mode-3 SPI byte transmitter for PmodOLED; same-DC bytes share one CS-low burst
module oled_spi_tx
  import oled_pkg::*;
#(
  parameter int CLK_DIV = 5,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          WR_EN,
  input  logic [7:0]                    WR_DATA,
  input  logic                          WR_DC,
  output logic                          FULL,
  output logic                          EMPTY,
  output logic [$clog2(FIFO_DEPTH):0]   LEVEL,
  output logic                          BUSY,
  output logic                          OVF,
  output logic                          CS,
  output logic                          SCLK,
  output logic                          SDO,
  output logic                          DC
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  state_e state_q;
  logic [DW-1:0] div_q;
  logic [2:0] bit_q;
  logic [7:0] sh_q;
  logic [8:0] head;
  logic cs_q, sclk_q, sdo_q, dc_q, div_end, last_bit, burst, pop;
  oled_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(CLK), .rst(RST), .wr_en_i(WR_EN), .wr_data_i({WR_DC, WR_DATA}), .pop_i(pop),
    .head_o(head), .full_o(FULL), .empty_o(EMPTY), .level_o(LEVEL), .ovf_o(OVF)
  );
  assign div_end = div_q == DW'(CLK_DIV - 1);
  assign last_bit = bit_q == 3'(SPI_BITS - 1);
  // a queued byte with the same DC rides the current frame without a SETUP/HOLD
  assign burst = state_q == SHIFT && sclk_q && div_end && last_bit && !EMPTY && head[8] == dc_q;
  assign pop = (state_q == IDLE && !EMPTY) || burst;
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cs_q <= 1'b1;
      sclk_q <= 1'b1;
      sdo_q <= 1'b0;
      dc_q <= DC_CMD;
      div_q <= '0;
      bit_q <= '0;
      sh_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (!EMPTY) begin
          sh_q <= head[7:0];
          dc_q <= head[8];
          cs_q <= 1'b0;
          div_q <= '0;
          state_q <= SETUP;
        end
        SETUP: if (div_end) begin
          div_q <= '0;
          bit_q <= '0;
          sclk_q <= 1'b0;
          sdo_q <= sh_q[7];
          state_q <= SHIFT;
        end else div_q <= div_q + DW'(1);
        SHIFT: if (!div_end) div_q <= div_q + DW'(1);
        else begin
          div_q <= '0;
          if (!sclk_q) sclk_q <= 1'b1;
          else if (!last_bit) begin
            bit_q <= bit_q + 3'd1;
            sclk_q <= 1'b0;
            sdo_q <= sh_q[6];
            sh_q <= {sh_q[6:0], 1'b0};
          end else if (burst) begin
            bit_q <= '0;
            sclk_q <= 1'b0;
            sdo_q <= head[7];
            sh_q <= head[7:0];
          end else state_q <= HOLD;
        end
        HOLD: if (div_end) begin
          div_q <= '0;
          cs_q <= 1'b1;
          state_q <= GAP;
        end else div_q <= div_q + DW'(1);
        GAP: if (div_end) begin
          div_q <= '0;
          state_q <= IDLE;
        end else div_q <= div_q + DW'(1);
        default: state_q <= IDLE;
      endcase
    end
  end
  assign BUSY = state_q != IDLE || !EMPTY;
  assign CS = cs_q;
  assign SCLK = sclk_q;
  assign SDO = sdo_q;
  assign DC = dc_q;
endmodule

// File: tb/tb_oled_spi_tx.sv
// tb_oled_spi_tx: directed and random stimulus checked every cycle against a frame-timeline model
module tb_oled_spi_tx;
  localparam int D = 2;
  localparam int DEPTH = 8;
  logic clk = 0, rst = 1, wr_en = 0, wr_dc = 0;
  logic [7:0] wr_data = 0;
  logic full, empty, busy, ovf, cs, sclk, sdo, dc;
  logic [3:0] level;
  int vectors = 0, miscompares = 0;

  oled_spi_tx #(.CLK_DIV(D), .FIFO_DEPTH(DEPTH)) dut (
    .CLK(clk), .RST(rst), .WR_EN(wr_en), .WR_DATA(wr_data), .WR_DC(wr_dc),
    .FULL(full), .EMPTY(empty), .LEVEL(level), .BUSY(busy), .OVF(ovf),
    .CS(cs), .SCLK(sclk), .SDO(sdo), .DC(dc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // model: a queue of pending entries plus a timeline counter t within the current frame
  logic [8:0] mq[$];
  logic [8:0] tmp;
  int ph = 0, t = 0, nb = 0, o;
  logic [7:0] cur = 0;
  logic mdc = 0, movf = 0, esdo = 0, ecs = 1, esclk = 1;
  bit mvalid = 0, full_old;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      ph = 0; t = 0; nb = 0; mdc = 0; movf = 0; esdo = 0; mvalid = 1;
    end else begin
      full_old = mq.size() == DEPTH;
      case (ph)
        0: if (mq.size() > 0) begin
          tmp = mq.pop_front();
          {mdc, cur} = tmp; nb = 1; t = 0; ph = 1;
        end
        1: begin
          t++;
          if (t == D + 16*D*nb && mq.size() > 0 && mq[0][8] == mdc) begin
            tmp = mq.pop_front();
            cur = tmp[7:0]; nb++;
          end else if (t == D + 16*D*nb + D) begin
            ph = 2; t = 0;
          end
        end
        default: begin
          t++;
          if (t == D) ph = 0;
        end
      endcase
      if (wr_en) begin
        if (full_old) movf = 1;
        else mq.push_back({wr_dc, wr_data});
      end
    end
    ecs = ph != 1;
    esclk = 1;
    if (ph == 1 && t >= D && t < D + 16*D*nb) begin
      o = (t - D) % (16*D);
      esclk = (o % (2*D)) >= D;
      esdo = cur[7 - o/(2*D)];
    end
  end

  always @(negedge clk) if (mvalid) begin
    chk("cs", cs, ecs);
    chk("sclk", sclk, esclk);
    chk("sdo", sdo, esdo);
    chk("dc", dc, mdc);
    chk("level", level, mq.size());
    chk("full", full, mq.size() == DEPTH);
    chk("empty", empty, mq.size() == 0);
    chk("ovf", ovf, movf);
    chk("busy", busy, ph != 0 || mq.size() > 0);
  end

  // slave-side capture: bytes sampled on SCLK rises, frame lengths and edge counts
  logic [7:0] rxq[$], rxsh = 0;
  int fe[$], fl[$];
  int nedge = 0, clen = 0, rxbits = 0, sclk_chg = 0;
  logic psclk = 1, pcs = 1;
  always @(negedge clk) begin
    if (cs === 1'b0 && sclk === 1'b1 && psclk === 1'b0) begin
      rxsh = {rxsh[6:0], sdo};
      nedge++; rxbits++;
      if (rxbits == 8) begin rxq.push_back(rxsh); rxbits = 0; end
    end
    if (cs === 1'b0) clen++;
    if (cs === 1'b1 && pcs === 1'b0) begin
      fe.push_back(nedge); fl.push_back(clen);
      nedge = 0; clen = 0; rxbits = 0;
    end
    if (sclk !== psclk) sclk_chg++;
    psclk = sclk; pcs = cs;
  end

  task automatic clear_cap();
    rxq.delete(); fe.delete(); fl.delete();
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 3000) begin @(negedge clk); n++; end
    if (n >= 3000) chk("idle_timeout", 1, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] d, input logic c);
    @(negedge clk);
    wr_en = 1; wr_data = d; wr_dc = c;
  endtask

  task automatic wr_stop();
    @(negedge clk);
    wr_en = 0;
  endtask

  task automatic chk_rx(input string name, input logic [7:0] exp[$]);
    chk({name, "_count"}, rxq.size(), exp.size());
    foreach (exp[i]) chk(name, (i < rxq.size()) ? rxq[i] : 8'hxx, exp[i]);
  endtask

  initial begin
    int n;
    logic [7:0] exp[$];
    rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cs", cs, 1); chk("rst_sclk", sclk, 1); chk("rst_sdo", sdo, 0);
    chk("rst_dc", dc, 0); chk("rst_empty", empty, 1); chk("rst_full", full, 0);
    chk("rst_level", level, 0); chk("rst_ovf", ovf, 0); chk("rst_busy", busy, 0);
    rst = 0;
    repeat (3) @(negedge clk);
    clear_cap();

    // single command: launched at edge k, sampled at k+1, CS low after k+2
    @(posedge clk); #1 wr_en = 1; wr_data = 8'hAE; wr_dc = 0;
    @(posedge clk); #1 wr_en = 0;
    @(negedge clk); chk("cs_before_fall", cs, 1);
    @(negedge clk); chk("cs_fall", cs, 0);
    wait_idle();
    chk("single_frames", fe.size(), 1);
    if (fe.size() == 1) begin
      chk("single_edges", fe[0], 8); chk("single_cs_len", fl[0], 18*D);
    end
    exp = '{8'hAE}; chk_rx("single_rx", exp);
    clear_cap();

    foreach (exp[i]) ;
    exp = '{8'h01, 8'h02, 8'h04, 8'h08};
    foreach (exp[i]) wr(exp[i], 1);
    wr_stop();
    wait_idle();
    chk("burst_frames", fe.size(), 1);
    if (fe.size() == 1) begin
      chk("burst_edges", fe[0], 32); chk("burst_cs_len", fl[0], D*(2 + 64));
    end
    chk_rx("burst_rx", exp);
    clear_cap();

    wr(8'h8D, 0); wr(8'h14, 0); wr(8'hFF, 1); wr_stop();
    wait_idle();
    chk("dcsw_frames", fe.size(), 2);
    if (fe.size() == 2) begin
      chk("dcsw_edges1", fe[0], 16); chk("dcsw_edges2", fe[1], 8);
      chk("dcsw_len1", fl[0], D*(2 + 32));
    end
    chk("dcsw_dc_after", dc, 1);
    exp = '{8'h8D, 8'h14, 8'hFF}; chk_rx("dcsw_rx", exp);
    clear_cap();

    exp.delete();
    for (int i = 0; i < 10; i++) begin
      wr(8'h30 + 8'(i), 0);
      if (i < 9) exp.push_back(8'h30 + 8'(i));
    end
    wr_stop();
    chk("ovf_full", full, 1); chk("ovf_level", level, 8); chk("ovf_flag", ovf, 1);
    wait_idle();
    chk_rx("ovf_rx", exp);
    chk("ovf_frames", fe.size(), 1);
    clear_cap();

    wr(8'hA5, 1); wr(8'h3C, 1); wr(8'h5A, 1); wr(8'hC3, 1); wr_stop();
    n = 0;
    while (nedge < 4 && n < 500) begin @(negedge clk); n++; end
    chk("mid_wait", n < 500, 1);
    rst = 1;
    @(negedge clk);
    chk("mid_cs", cs, 1); chk("mid_sclk", sclk, 1); chk("mid_level", level, 0); chk("mid_ovf", ovf, 0);
    rst = 0;
    n = sclk_chg;
    repeat (50) @(negedge clk);
    chk("mid_quiet", sclk_chg - n, 0);
    chk("mid_cs_idle", cs, 1);
    clear_cap();

    repeat (800) begin
      @(negedge clk);
      wr_en = $urandom_range(0, 3) == 0;
      wr_data = 8'($urandom);
      if ($urandom_range(0, 7) == 0) wr_dc = ~wr_dc;
    end
    wr_stop();
    wait_idle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
